ab_req_responder: RTL and testbench

- Responder end of the a/b request-acknowledge handshake checked by the chapter-2 assertions.
- Accepts a level request `a` with a data word and returns a one-cycle acknowledge `b` a fixed number of cycles later, echoing the captured data.
- Tracks completed and aborted transactions.
- Serves as the DUT that drives `b` so that a|->b style properties can be exercised in both passing and failing configurations.

---
 rtl/ab_req_responder_if.sv | 27 ++
 rtl/ab_req_responder.sv | 130 +++++++++++++
 tb/tb_ab_req_responder.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ab_req_responder_if.sv
// Request/acknowledge bundle between an initiator and ab_req_responder.
// Latency: none, wires only.
// Backpressure: none; the initiator holds `a` until it sees `b`.
interface ab_req_responder_if #(
  parameter int DW = 8,
  parameter int CW = 8
);
  logic          a;
  logic [DW-1:0] req_data;
  logic          b;
  logic [DW-1:0] rsp_data;
  logic          busy;
  logic          abort;
  logic [CW-1:0] txn_cnt;

  // Initiator side: raises the request, watches the acknowledge.
  modport master (
    output a, req_data,
    input  b, rsp_data, busy, abort, txn_cnt
  );

  // Responder side: samples the request, drives the acknowledge.
  modport slave (
    input  a, req_data,
    output b, rsp_data, busy, abort, txn_cnt
  );
endinterface

// File: rtl/ab_req_responder.sv
// Responder for the a/b level-request / pulse-acknowledge handshake.
// Latency: b rises LATENCY cycles after `a` is first seen high (0 = combinational).
// Backpressure: initiator holds `a`; dropping it before `b` aborts, one ack per held request.
module ab_req_responder #(
  parameter int LATENCY = 2,
  parameter int DW      = 8,
  parameter int CW      = 8
) (
  input logic              clk,
  input logic              rst,
  ab_req_responder_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2,
    HOLD = 2'd3
  } state_t;

  // WAIT exits to ACK when the delay counter reaches LATENCY-1; only
  // meaningful for LATENCY >= 2, clamped so the constant stays in range.
  localparam logic [3:0] LAST = 4'((LATENCY >= 2) ? (LATENCY - 1) : 0);
  localparam logic [CW-1:0] TXN_ONE = CW'(1);

  state_t        state;
  state_t        state_nxt;
  logic [3:0]    cnt;
  logic [3:0]    cnt_nxt;
  logic [DW-1:0] cap;
  logic          cap_en;
  logic          abort_q;
  logic          abort_nxt;
  logic [CW-1:0] txn_q;
  logic          txn_inc;

  // State register, delay counter, captured payload, abort pulse and counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      cap     <= '0;
      abort_q <= 1'b0;
      txn_q   <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      abort_q <= abort_nxt;
      if (cap_en) begin
        cap <= bus.req_data;
      end
      // Counter sticks at all-ones once it gets there.
      if (txn_inc && !(&txn_q)) begin
        txn_q <= txn_q + TXN_ONE;
      end
    end
  end

  // Next-state decode: accept only from IDLE, abort on withdrawal in WAIT.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cap_en    = 1'b0;
    abort_nxt = 1'b0;
    txn_inc   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.a) begin
          cap_en = 1'b1;
          if (LATENCY == 0) begin
            // Acknowledge already went out combinationally this cycle.
            txn_inc   = 1'b1;
            state_nxt = HOLD;
          end else if (LATENCY == 1) begin
            state_nxt = ACK;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = 4'd1;
          end
        end
      end
      WAIT: begin
        if (!bus.a) begin
          // Withdrawal beats reaching the target count.
          state_nxt = IDLE;
          cnt_nxt   = 4'd0;
          abort_nxt = 1'b1;
        end else if (cnt == LAST) begin
          state_nxt = ACK;
          cnt_nxt   = 4'd0;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      ACK: begin
        // The acknowledge completes even if `a` dropped during this cycle.
        txn_inc   = 1'b1;
        state_nxt = HOLD;
      end
      HOLD: begin
        if (!bus.a) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Acknowledge and response data: Moore from ACK, or a straight pass-through
  // of the request in IDLE when LATENCY is zero.
  always_comb begin
    bus.b        = 1'b0;
    bus.rsp_data = cap;
    if (LATENCY == 0) begin
      if (state == IDLE) begin
        bus.b        = bus.a;
        bus.rsp_data = bus.req_data;
      end
    end else begin
      bus.b = (state == ACK);
    end
  end

  assign bus.busy    = (state != IDLE);
  assign bus.abort   = abort_q;
  assign bus.txn_cnt = txn_q;

endmodule

// File: tb/tb_ab_req_responder.sv
// Bench for ab_req_responder: seven instances with different LATENCY/CW run in parallel.
// Each is compared every cycle against a cycles-since-accept model plus literal pins.
// Stimulus is directed, one table per instance, indexed by cycle number.
module tb_ab_req_responder;

  localparam int N = 7;

  logic       clk;
  logic       a_s     [N];
  logic [7:0] d_s     [N];
  logic       rst_s   [N];
  logic       b_o     [N];
  logic [7:0] rsp_o   [N];
  logic       busy_o  [N];
  logic       abort_o [N];
  logic [7:0] cnt_o   [N];

  int checks   = 0;
  int failures = 0;
  int cyc      = -1;
  bit run      = 1'b0;
  int nb       [N] = '{default: 0};

  // Model state: cycles since acceptance (-1 = idle), captured data,
  // transaction count and pending abort pulse.
  int         since [N] = '{default: -1};
  logic [7:0] cap_m [N] = '{default: 8'h00};
  int         txn_m [N] = '{default: 0};
  bit         ab_m  [N] = '{default: 1'b0};

  function automatic int lat_of(input int i);
    case (i)
      0: return 2;
      1: return 3;
      2: return 2;
      3: return 4;
      4: return 1;
      5: return 0;
      default: return 1;
    endcase
  endfunction

  function automatic int cw_of(input int i);
    return (i == 4) ? 2 : 8;
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int LV = lat_of(g);
    localparam int CV = cw_of(g);
    ab_req_responder_if #(.DW(8), .CW(CV)) ifc ();
    ab_req_responder #(.LATENCY(LV), .DW(8), .CW(CV)) dut (
      .clk (clk),
      .rst (rst_s[g]),
      .bus (ifc)
    );
    assign ifc.a        = a_s[g];
    assign ifc.req_data = d_s[g];
    assign b_o[g]       = ifc.b;
    assign rsp_o[g]     = ifc.rsp_data;
    assign busy_o[g]    = ifc.busy;
    assign abort_o[g]   = ifc.abort;
    assign cnt_o[g]     = 8'(ifc.txn_cnt);
  end

  task automatic check(input string name, input int inst, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst%0d cyc%0d got=%0h want=%0h", name, inst, cyc, act, exp);
    end
  endtask

  // Per-cycle stimulus tables.
  task automatic apply(input int t);
    a_s[0] = (t <= 5);                     d_s[0] = 8'hA5;
    a_s[1] = (t <= 1);                     d_s[1] = 8'h5A;
    a_s[2] = (t <= 7) || (t >= 9 && t <= 13);
    d_s[2] = (t < 9) ? 8'hC3 : 8'h3C;
    a_s[3] = (t <= 1) || (t >= 4 && t <= 10);
    d_s[3] = (t < 4) ? 8'h77 : 8'h99;
    rst_s[3] = (t == 2);
    a_s[4] = (t < 15) && (t % 3 != 2);     d_s[4] = 8'(t / 3 + 1);
    a_s[5] = (t == 5);                     d_s[5] = (t == 5) ? 8'h11 : 8'h00;
    a_s[6] = (t == 5);                     d_s[6] = (t == 5) ? 8'h11 : 8'h00;
  endtask

  // Model advance on each rising edge, from the inputs held during the cycle.
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      int lat;
      int mx;
      lat = lat_of(i);
      mx  = (1 << cw_of(i)) - 1;
      if (rst_s[i]) begin
        since[i] = -1;
        cap_m[i] = 8'h00;
        txn_m[i] = 0;
        ab_m[i]  = 1'b0;
      end else begin
        ab_m[i] = 1'b0;
        if (since[i] < 0) begin
          if (a_s[i]) begin
            cap_m[i] = d_s[i];
            since[i] = 1;
            if (lat == 0) txn_m[i] = (txn_m[i] < mx) ? txn_m[i] + 1 : mx;
          end
        end else if (since[i] < lat) begin
          if (!a_s[i]) begin
            since[i] = -1;
            ab_m[i]  = 1'b1;
          end else begin
            since[i] = since[i] + 1;
          end
        end else if (since[i] == lat) begin
          txn_m[i] = (txn_m[i] < mx) ? txn_m[i] + 1 : mx;
          since[i] = lat + 1;
        end else if (!a_s[i]) begin
          since[i] = -1;
        end
      end
    end
  end

  // Compare every output of every instance against the model, plus literal pins.
  always @(negedge clk) begin
    if (run) begin
      for (int i = 0; i < N; i++) begin
        int  lat;
        bit  idle;
        bit  eb;
        logic [7:0] er;
        lat  = lat_of(i);
        idle = (since[i] < 0);
        eb   = (lat == 0) ? (idle && a_s[i]) : (since[i] == lat);
        er   = (lat == 0 && idle) ? d_s[i] : cap_m[i];
        check("b", i, b_o[i], eb);
        check("rsp_data", i, rsp_o[i], er);
        check("busy", i, busy_o[i], !idle);
        check("abort", i, abort_o[i], ab_m[i]);
        check("txn_cnt", i, cnt_o[i], txn_m[i]);
        if (cyc < 0) begin
          check("reset_zero", i, {b_o[i], busy_o[i], abort_o[i], cnt_o[i], rsp_o[i]}, 0);
        end else begin
          nb[i] = nb[i] + (b_o[i] ? 1 : 0);
        end
      end
      case (cyc)
        1: begin
          check("lit_busy", 0, busy_o[0], 1);
          check("lit_b", 0, b_o[0], 0);
        end
        2: begin
          check("lit_b", 0, b_o[0], 1);
          check("lit_rsp", 0, rsp_o[0], 8'hA5);
          check("lit_b", 2, b_o[2], 1);
          check("lit_cnt", 4, cnt_o[4], 1);
        end
        3: begin
          check("lit_cnt", 0, cnt_o[0], 1);
          check("lit_abort", 1, abort_o[1], 1);
          check("lit_busy", 1, busy_o[1], 0);
          check("lit_b", 1, b_o[1], 0);
          check("lit_rst_busy", 3, busy_o[3], 0);
          check("lit_rst_abort", 3, abort_o[3], 0);
          check("lit_rst_rsp", 3, rsp_o[3], 0);
          check("lit_rst_b", 3, b_o[3], 0);
        end
        4: check("lit_abort", 1, abort_o[1], 0);
        5: begin
          check("lit_b", 5, b_o[5], 1);
          check("lit_rsp", 5, rsp_o[5], 8'h11);
          check("lit_b", 6, b_o[6], 0);
          check("prop_a_imp_b", 6, (!a_s[6]) || b_o[6], 0);
          check("lit_cnt", 4, cnt_o[4], 2);
        end
        6: begin
          check("lit_busy", 0, busy_o[0], 1);
          check("lit_b", 6, b_o[6], 1);
          check("lit_rsp", 6, rsp_o[6], 8'h11);
          check("lit_b", 5, b_o[5], 0);
          check("lit_cnt", 5, cnt_o[5], 1);
        end
        7: check("lit_busy", 0, busy_o[0], 0);
        8: begin
          check("lit_b", 3, b_o[3], 1);
          check("lit_cnt", 4, cnt_o[4], 3);
        end
        9: check("lit_cnt", 3, cnt_o[3], 1);
        11: begin
          check("lit_b", 2, b_o[2], 1);
          check("lit_rsp", 2, rsp_o[2], 8'h3C);
          check("lit_cnt", 4, cnt_o[4], 3);
        end
        12: check("lit_cnt", 2, cnt_o[2], 2);
        14: check("lit_cnt", 4, cnt_o[4], 3);
        default: ;
      endcase
      if (cyc >= 0) begin
        check("prop_a_imp_b", 5, (!a_s[5]) || b_o[5], 1);
      end
    end
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      a_s[i]   = 1'b0;
      d_s[i]   = 8'h00;
      rst_s[i] = 1'b1;
    end
    @(posedge clk);
    #1;
    run = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) rst_s[i] = 1'b0;
    cyc = 0;
    apply(0);
    for (int t = 1; t < 40; t++) begin
      @(posedge clk);
      #1;
      cyc = t;
      apply(t);
    end
    @(negedge clk);
    #1;
    check("b_pulses", 0, nb[0], 1);
    check("b_pulses", 1, nb[1], 0);
    check("b_pulses", 2, nb[2], 2);
    check("b_pulses", 3, nb[3], 1);
    check("b_pulses", 4, nb[4], 5);
    check("b_pulses", 5, nb[5], 1);
    check("b_pulses", 6, nb[6], 1);
    check("final_cnt", 1, cnt_o[1], 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
